jk_toggle_monitor: RTL and testbench

Downstream observer for the JK flip-flop stage: samples the flop's `q`/`qbar` pair, counts rising and falling transitions of `q` over a fixed window of clock cycles, and reports both counts through a valid/ready handshake. A sticky error flag catches the illegal `q == qbar` condition. It sits directly after the JK flop in toggle-test and counter-verification chains.

---
 rtl/jk_toggle_monitor.sv | 146 ++++++++++++++
 tb/tb_jk_toggle_monitor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_toggle_monitor.sv
// jk_toggle_monitor: counts rising/falling transitions of a JK flop's q over a
// WIN-cycle window and reports both counts, plus sticky q==qbar and lost flags.
// Latency: q_in change at edge k counts at edge k+2 (sync) or edge k (no sync).
// Backpressure: counts held with cnt_valid until cnt_ready; edges seen meanwhile set lost.
//
// Ports:
//   clk, clr (sync active-low reset)  q_in, qbar_in (flop outputs)  en (run)
//   rise_cnt, fall_cnt, cnt_valid / cnt_ready (report handshake)  lost, err (sticky)
// Build option: define JK_TOGGLE_MONITOR_SYNC_EN to put 2-flop synchronizers on
// q_in/qbar_in when the observed flop runs on another or a gated clock.
module jk_toggle_monitor #(
  parameter int CNT_W = 8,
  parameter int WIN   = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             q_in,
  input  logic             qbar_in,
  input  logic             en,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             lost,
  output logic             err
);

  localparam int WIN_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t           state;
  logic [WIN_W-1:0] win_cnt;
  logic             q_s;
  logic             qbar_s;
  logic             q_prev;
  logic             rise;
  logic             fall;

`ifdef JK_TOGGLE_MONITOR_SYNC_EN
  logic [1:0] q_sync;
  logic [1:0] qbar_sync;

  always_ff @(posedge clk) begin
    if (!clr) begin
      q_sync    <= '0;
      qbar_sync <= '0;
    end else begin
      q_sync    <= {q_sync[0], q_in};
      qbar_sync <= {qbar_sync[0], qbar_in};
    end
  end

  assign q_s    = q_sync[1];
  assign qbar_s = qbar_sync[1];
`else
  assign q_s    = q_in;
  assign qbar_s = qbar_in;
`endif

  // Edge detect against the previous sample; q_prev tracks in every state so
  // the first counted edge of a window compares against a real prior sample.
  assign rise = q_s & ~q_prev;
  assign fall = ~q_s & q_prev;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state     <= IDLE;
      win_cnt   <= '0;
      rise_cnt  <= '0;
      fall_cnt  <= '0;
      q_prev    <= 1'b0;
      cnt_valid <= 1'b0;
      lost      <= 1'b0;
      err       <= 1'b0;
    end else begin
      q_prev <= q_s;
      case (state)
        IDLE: begin
          if (en) begin
            state    <= COUNT;
            win_cnt  <= '0;
            rise_cnt <= '0;
            fall_cnt <= '0;
          end
        end

        COUNT: begin
          // Illegal complementary pair is flagged even on an abort edge.
          if (q_s == qbar_s) begin
            err <= 1'b1;
          end
          if (!en) begin
            // Aborted window: the partial counts are meaningless, drop them.
            state    <= IDLE;
            win_cnt  <= '0;
            rise_cnt <= '0;
            fall_cnt <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
            if (rise && (rise_cnt != '1)) begin
              rise_cnt <= rise_cnt + 1'b1;
            end
            if (fall && (fall_cnt != '1)) begin
              fall_cnt <= fall_cnt + 1'b1;
            end
            if (win_cnt == WIN_LAST) begin
              state     <= REPORT;
              win_cnt   <= '0;
              cnt_valid <= 1'b1;
            end
          end
        end

        REPORT: begin
          if (rise || fall) begin
            lost <= 1'b1;
          end
          // cnt_valid is always high here, so cnt_ready alone completes it.
          if (cnt_ready) begin
            cnt_valid <= 1'b0;
            if (en) begin
              state    <= COUNT;
              win_cnt  <= '0;
              rise_cnt <= '0;
              fall_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state     <= IDLE;
          cnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_toggle_monitor.sv
module tb_jk_toggle_monitor;

  localparam int WIN = 16;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       q_in = 1'b0;
  logic       qbar_in = 1'b1;
  logic       en = 1'b0;
  logic       cnt_ready = 1'b1;

  logic [7:0] rise_cnt, fall_cnt;
  logic       cnt_valid, lost, err;
  logic [1:0] rise_cnt2, fall_cnt2;
  logic       cnt_valid2, lost2, err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_toggle_monitor #(.CNT_W(8), .WIN(WIN)) dut (
    .clk(clk), .clr(clr), .q_in(q_in), .qbar_in(qbar_in), .en(en),
    .rise_cnt(rise_cnt), .fall_cnt(fall_cnt), .cnt_valid(cnt_valid),
    .cnt_ready(cnt_ready), .lost(lost), .err(err)
  );

  // Narrow-counter instance on the same stimulus exercises saturation.
  jk_toggle_monitor #(.CNT_W(2), .WIN(WIN)) dut_w2 (
    .clk(clk), .clr(clr), .q_in(q_in), .qbar_in(qbar_in), .en(en),
    .rise_cnt(rise_cnt2), .fall_cnt(fall_cnt2), .cnt_valid(cnt_valid2),
    .cnt_ready(cnt_ready), .lost(lost2), .err(err2)
  );

  // Reference model: phase of the observer, the q_s samples of the current
  // window (first entry is the sample before the window), and sticky flags.
  int m_phase = 0;        // 0 idle, 1 counting, 2 reporting
  bit m_win[$];
  bit m_qh[$];
  bit m_qbh[$];
  bit m_prev = 1'b0;
  bit m_lost = 1'b0;
  bit m_err  = 1'b0;
  bit m_rst  = 1'b0;
  int m_rise = 0;
  int m_fall = 0;
  int m_reports = 0;

  function automatic int transitions(input bit s[$], input bit to_val);
    int n = 0;
    for (int i = 1; i < s.size(); i++)
      if (s[i] == to_val && s[i-1] != to_val) n++;
    return n;
  endfunction

  function automatic int sat(input int n, input int w);
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit qs, qbs;
    if (!clr) begin
      m_phase = 0; m_prev = 1'b0; m_lost = 1'b0; m_err = 1'b0; m_rst = 1'b1;
      m_win.delete();
      m_qh = '{1'b0, 1'b0}; m_qbh = '{1'b0, 1'b0};
      return;
    end
    m_rst = 1'b0;
`ifdef JK_TOGGLE_MONITOR_SYNC_EN
    qs = m_qh[0];  void'(m_qh.pop_front());  m_qh.push_back(q_in);
    qbs = m_qbh[0]; void'(m_qbh.pop_front()); m_qbh.push_back(qbar_in);
`else
    qs = q_in; qbs = qbar_in;
`endif
    case (m_phase)
      0: if (en) begin m_phase = 1; m_win.delete(); end
      1: begin
        if (qs == qbs) m_err = 1'b1;
        if (!en) m_phase = 0;
        else begin
          if (m_win.size() == 0) m_win.push_back(m_prev);
          m_win.push_back(qs);
          if (m_win.size() == WIN + 1) begin
            m_phase = 2;
            m_rise = transitions(m_win, 1'b1);
            m_fall = transitions(m_win, 1'b0);
          end
        end
      end
      default: begin
        if (qs != m_prev) m_lost = 1'b1;
        if (cnt_ready) begin
          m_phase = en ? 1 : 0;
          m_win.delete();
        end
      end
    endcase
    m_prev = qs;
  endtask

  // One clock: update the model from the inputs in force at the edge, then
  // compare registered outputs 1ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("cnt_valid", cnt_valid, m_phase == 2);
    chk("cnt_valid_w2", cnt_valid2, m_phase == 2);
    chk("lost", lost, m_lost);
    chk("err", err, m_err);
    chk("lost_w2", lost2, m_lost);
    chk("err_w2", err2, m_err);
    if (m_phase == 2) begin
      m_reports++;
      chk("rise_cnt", rise_cnt, sat(m_rise, 8));
      chk("fall_cnt", fall_cnt, sat(m_fall, 8));
      chk("rise_cnt_sat", rise_cnt2, sat(m_rise, 2));
      chk("fall_cnt_sat", fall_cnt2, sat(m_fall, 2));
    end
    if (m_rst) begin
      chk("rst_rise", rise_cnt, 0);
      chk("rst_fall", fall_cnt, 0);
      chk("rst_rise_w2", rise_cnt2, 0);
      chk("rst_fall_w2", fall_cnt2, 0);
    end
  endtask

  task automatic set_q(input bit v);
    q_in = v; qbar_in = ~v;
  endtask

  initial begin
    int rep0;

    // Reset and idle.
    clr = 1'b0; tick(); tick();
    clr = 1'b1; tick();

    // Toggle every 2 cycles starting low, ready high.
    en = 1'b1;
    for (int i = 0; i < 3 * (WIN + 1); i++) begin
      set_q(((i / 2) % 2) != 0);
      tick();
    end

    // Quiet line gives a 0/0 report, then q == qbar for 3 cycles.
    set_q(1'b0);
    for (int i = 0; i < 2 * (WIN + 1); i++) tick();
    q_in = 1'b1; qbar_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    set_q(1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("err_sticky", err, 1);
    clr = 1'b0; tick(); clr = 1'b1;
    chk("err_cleared", err, 0);

    // Toggle every cycle: 8-bit counts exceed the 2-bit counter range.
    for (int i = 0; i < 2 * (WIN + 1) + 4; i++) begin
      set_q(i[0]);
      tick();
    end

    // Consumer stalls with random toggles while the report is held.
    cnt_ready = 1'b0;
    for (int i = 0; i < 60 && m_phase != 2; i++) begin
      set_q(1'($urandom));
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      set_q(1'($urandom));
      tick();
    end
    cnt_ready = 1'b1;
    for (int i = 0; i < 2 * (WIN + 1); i++) begin
      set_q(1'($urandom));
      tick();
    end

    // Abort at window cycle 8, then a full window after re-enable.
    en = 1'b0; tick(); tick();
    clr = 1'b0; tick(); clr = 1'b1;
    en = 1'b1;
    rep0 = m_reports;
    for (int i = 0; i < 9; i++) begin set_q(1'($urandom)); tick(); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("abort_no_report", m_reports - rep0, 0);
    en = 1'b1;
    for (int i = 0; i < WIN + 2; i++) begin set_q(1'($urandom)); tick(); end
    chk("full_window_report", m_reports - rep0, 1);

    // Reset mid-count, then mid-report.
    for (int i = 0; i < 5; i++) begin set_q(1'($urandom)); tick(); end
    clr = 1'b0; tick(); clr = 1'b1;
    cnt_ready = 1'b0;
    for (int i = 0; i < 60 && m_phase != 2; i++) begin set_q(1'($urandom)); tick(); end
    chk("reached_report", m_phase, 2);
    clr = 1'b0; tick(); clr = 1'b1;
    cnt_ready = 1'b1;

    // Random soak: mostly-complementary q/qbar, random en, ready and resets.
    for (int i = 0; i < 800; i++) begin
      en = ($urandom_range(0, 19) != 0);
      q_in = 1'($urandom);
      qbar_in = ($urandom_range(0, 59) == 0) ? q_in : ~q_in;
      cnt_ready = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 149) != 0);
      tick();
    end
    chk("soak_reports_seen", (m_reports > 0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
